// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit writing a HI/LO register pair.
// Divider is built only when MULDIV_DIV_EN is defined.
module muldiv_unit #(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cancel_i,
    output logic        busy_o,
    output logic        hilo_we_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] DIV  = 2'd2;
`endif
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [5:0] MUL_LAST = 6'(MUL_STAGES - 1);

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sgn_q;

    logic signed [63:0] ma;
    logic signed [63:0] mb;
    logic signed [63:0] prod;

    // Product of the captured operands, sign- or zero-extended by op
    always_comb begin
        ma   = {{32{sgn_q & a_q[31]}}, a_q};
        mb   = {{32{sgn_q & b_q[31]}}, b_q};
        prod = ma * mb;
    end

`ifdef MULDIV_DIV_EN
    logic [31:0] rem;
    logic [31:0] quo;
    logic [31:0] dvs;
    logic        negq;
    logic        negr;
    logic        dz;
    logic [32:0] sh;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // One restoring step on magnitudes plus final sign fix-up
    always_comb begin
        sh    = {rem, quo[31]};
        diff  = sh - {1'b0, dvs};
        q_fix = negq ? -quo : quo;
        r_fix = negr ? -rem : rem;
    end
`endif

    // Control FSM with operand capture and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hi_o  <= '0;
            lo_o  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i && !cancel_i) begin
                        a_q   <= a_i;
                        b_q   <= b_i;
                        sgn_q <= ~op_i[0];
                        cnt   <= '0;
                        if (!op_i[1]) begin
                            state <= MUL;
                        end
`ifdef MULDIV_DIV_EN
                        else begin
                            state <= DIV;
                            rem   <= '0;
                            quo   <= (~op_i[0] & a_i[31]) ? -a_i : a_i;
                            dvs   <= (~op_i[0] & b_i[31]) ? -b_i : b_i;
                            negq  <= ~op_i[0] & (a_i[31] ^ b_i[31]);
                            negr  <= ~op_i[0] & a_i[31];
                            dz    <= (b_i == 32'd0);
                        end
`endif
                    end
                end
                MUL: begin
                    if (cancel_i) begin
                        state <= IDLE;
                    end else if (cnt == MUL_LAST) begin
                        state <= DONE;
                        hi_o  <= prod[63:32];
                        lo_o  <= prod[31:0];
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
`ifdef MULDIV_DIV_EN
                DIV: begin
                    if (cancel_i) begin
                        state <= IDLE;
                    end else if (cnt == 6'd32) begin
                        state <= DONE;
                        hi_o  <= dz ? a_q : r_fix;
                        lo_o  <= dz ? 32'hFFFF_FFFF : q_fix;
                    end else begin
                        cnt <= cnt + 6'd1;
                        quo <= {quo[30:0], ~diff[32]};
                        rem <= diff[32] ? sh[31:0] : diff[31:0];
                    end
                end
`endif
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Status decode straight from the state register
    always_comb begin
        hilo_we_o = (state == DONE);
`ifdef MULDIV_DIV_EN
        busy_o    = (state == MUL) || (state == DIV);
`else
        busy_o    = (state == MUL);
`endif
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (MUL_STAGES=2).
// Division cases run only when MULDIV_DIV_EN is defined.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cancel_i;
    logic        busy_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    muldiv_unit #(.MUL_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .cancel_i  (cancel_i),
        .busy_o    (busy_o),
        .hilo_we_o (hilo_we_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int ecyc);
        int n;
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        step();
        start_i = 1'b0;
        op_i    = ~op;
        a_i     = ~a;
        b_i     = ~b;
        n = 0;
        while (busy_o === 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_busycyc"}, 32'(n), 32'(ecyc));
        chk({tag, "_we"}, {31'd0, hilo_we_o}, 32'd1);
        chk({tag, "_hi"}, hi_o, eh);
        chk({tag, "_lo"}, lo_o, el);
        step();
        chk({tag, "_we_off"}, {31'd0, hilo_we_o}, 32'd0);
        chk({tag, "_hi_hold"}, hi_o, eh);
        chk({tag, "_lo_hold"}, lo_o, el);
    endtask

    initial begin
        rst      = 1'b1;
        start_i  = 1'b0;
        op_i     = 2'd0;
        a_i      = 32'd0;
        b_i      = 32'd0;
        cancel_i = 1'b0;
        step();
        step();
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_we", {31'd0, hilo_we_o}, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        rst = 1'b0;
        step();

        run_op("mult_m2x3", OP_MULT, 32'hFFFF_FFFE, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);
        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 2);
        run_op("mult_neg_neg", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFF9,
               32'd0, 32'd35, 2);
        run_op("multu_msb", OP_MULTU, 32'h8000_0000, 32'd2,
               32'd1, 32'd0, 2);
        run_op("mult_msb", OP_MULT, 32'h8000_0000, 32'd2,
               32'hFFFF_FFFF, 32'd0, 2);
        run_op("mult_mix", OP_MULT, 32'h1234_5678, 32'h10,
               32'd1, 32'h2345_6780, 2);

        // Start during MUL ignored; cancel in DONE ignored
        start_i = 1'b1;
        op_i    = OP_MULT;
        a_i     = 32'd3;
        b_i     = 32'd4;
        step();
        op_i    = OP_MULTU;
        a_i     = 32'hFFFF_FFFF;
        b_i     = 32'hFFFF_FFFF;
        chk("ign_busy1", {31'd0, busy_o}, 32'd1);
        step();
        start_i = 1'b0;
        chk("ign_busy2", {31'd0, busy_o}, 32'd1);
        chk("ign_we_early", {31'd0, hilo_we_o}, 32'd0);
        step();
        cancel_i = 1'b1;
        #1;
        chk("ign_we", {31'd0, hilo_we_o}, 32'd1);
        chk("ign_lo", lo_o, 32'd12);
        chk("ign_hi", hi_o, 32'd0);
        step();
        cancel_i = 1'b0;
        chk("ign_idle_busy", {31'd0, busy_o}, 32'd0);
        chk("ign_idle_we", {31'd0, hilo_we_o}, 32'd0);

        // Back-to-back start right after DONE
        run_op("b2b", OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 2);

        // Cancel in MUL, simultaneous start dropped
        start_i = 1'b1;
        op_i    = OP_MULTU;
        a_i     = 32'hFFFF_FFFF;
        b_i     = 32'd2;
        step();
        cancel_i = 1'b1;
        step();
        cancel_i = 1'b0;
        start_i  = 1'b0;
        chk("mcan_busy", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("mcan_we", {31'd0, hilo_we_o}, 32'd0);
            chk("mcan_busy_hold", {31'd0, busy_o}, 32'd0);
            step();
        end
        chk("mcan_hi", hi_o, 32'd0);
        chk("mcan_lo", lo_o, 32'd42);

        // Start plus cancel in IDLE: cancel wins
        start_i  = 1'b1;
        cancel_i = 1'b1;
        op_i     = OP_MULT;
        a_i      = 32'd9;
        b_i      = 32'd9;
        step();
        start_i  = 1'b0;
        cancel_i = 1'b0;
        chk("sc_busy", {31'd0, busy_o}, 32'd0);
        step();
        step();
        chk("sc_we", {31'd0, hilo_we_o}, 32'd0);
        chk("sc_lo", lo_o, 32'd42);

`ifdef MULDIV_DIV_EN
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("divu_100_0", OP_DIVU, 32'd100, 32'd0,
               32'd100, 32'hFFFF_FFFF, 33);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               32'd0, 32'h8000_0000, 33);
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7,
               32'd2, 32'd14, 33);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD, 33);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10,
               32'hF, 32'h0FFF_FFFF, 33);
        run_op("div_neg_0", OP_DIV, 32'hFFFF_FF9C, 32'd0,
               32'hFFFF_FF9C, 32'hFFFF_FFFF, 33);

        // DIVU cancelled at cycle 10, start in the same cycle ignored
        start_i = 1'b1;
        op_i    = OP_DIVU;
        a_i     = 32'd1000;
        b_i     = 32'd3;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("dcan_busy_pre", {31'd0, busy_o}, 32'd1);
        cancel_i = 1'b1;
        start_i  = 1'b1;
        step();
        cancel_i = 1'b0;
        start_i  = 1'b0;
        chk("dcan_busy", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (hilo_we_o !== 1'b0 || busy_o !== 1'b0) begin
                chk("dcan_quiet", {30'd0, busy_o, hilo_we_o}, 32'd0);
                break;
            end
            step();
        end
        chk("dcan_hi", hi_o, 32'hFFFF_FF9C);
        chk("dcan_lo", lo_o, 32'hFFFF_FFFF);

        // Reset at cycle 20 of DIV
        start_i = 1'b1;
        op_i    = OP_DIV;
        a_i     = 32'd500;
        b_i     = 32'd7;
        step();
        start_i = 1'b0;
        for (int i = 0; i < 19; i++) step();
        chk("drst_busy_pre", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("drst_busy", {31'd0, busy_o}, 32'd0);
        chk("drst_we", {31'd0, hilo_we_o}, 32'd0);
        chk("drst_hi", hi_o, 32'd0);
        chk("drst_lo", lo_o, 32'd0);
        for (int i = 0; i < 20; i++) step();
        chk("drst_we_after", {31'd0, hilo_we_o}, 32'd0);
        chk("drst_lo_after", lo_o, 32'd0);
`else
        // Division requests are dropped without the divider
        start_i = 1'b1;
        op_i    = OP_DIV;
        a_i     = 32'hFFFF_FFF9;
        b_i     = 32'd2;
        step();
        start_i = 1'b0;
        chk("nodiv_busy", {31'd0, busy_o}, 32'd0);
        for (int i = 0; i < 36; i++) begin
            if (hilo_we_o !== 1'b0 || busy_o !== 1'b0) begin
                chk("nodiv_quiet", {30'd0, busy_o, hilo_we_o}, 32'd0);
                break;
            end
            step();
        end
        start_i = 1'b1;
        op_i    = OP_DIVU;
        a_i     = 32'd100;
        b_i     = 32'd0;
        step();
        start_i = 1'b0;
        chk("nodivu_busy", {31'd0, busy_o}, 32'd0);
        step();
        chk("nodivu_we", {31'd0, hilo_we_o}, 32'd0);
        chk("nodiv_hi", hi_o, 32'd0);
        chk("nodiv_lo", lo_o, 32'd42);

        // Reset mid-multiply
        start_i = 1'b1;
        op_i    = OP_MULT;
        a_i     = 32'd5;
        b_i     = 32'd5;
        step();
        start_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy_o}, 32'd0);
        chk("mrst_we", {31'd0, hilo_we_o}, 32'd0);
        chk("mrst_hi", hi_o, 32'd0);
        chk("mrst_lo", lo_o, 32'd0);
        step();
        step();
        chk("mrst_we_after", {31'd0, hilo_we_o}, 32'd0);
        chk("mrst_lo_after", lo_o, 32'd0);
`endif

        run_op("final", OP_MULT, 32'hFFFF_FFFF, 32'd1,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
